// File: rtl/pipeline_ex_stage_pkg.sv
// pipeline_ex_stage_pkg: ID/EX bundle layouts, ALUFun codes, PCSrc encoding and the forwarding mux
package pipeline_ex_stage_pkg;
  localparam logic [5:0] ALU_ADD  = 6'b000000;
  localparam logic [5:0] ALU_SUB  = 6'b000001;
  localparam logic [5:0] ALU_AND  = 6'b011000;
  localparam logic [5:0] ALU_OR   = 6'b011110;
  localparam logic [5:0] ALU_XOR  = 6'b010110;
  localparam logic [5:0] ALU_NOR  = 6'b010001;
  localparam logic [5:0] ALU_PASS = 6'b011010;
  localparam logic [5:0] ALU_SLL  = 6'b100000;
  localparam logic [5:0] ALU_SRL  = 6'b100001;
  localparam logic [5:0] ALU_SRA  = 6'b100011;
  localparam logic [5:0] ALU_EQ   = 6'b110011;
  localparam logic [5:0] ALU_NE   = 6'b110001;
  localparam logic [5:0] ALU_LT   = 6'b110101;
  localparam logic [5:0] ALU_LEZ  = 6'b111101;
  localparam logic [5:0] ALU_LTZ  = 6'b111011;
  localparam logic [5:0] ALU_GTZ  = 6'b111111;
  localparam logic [2:0] PCSRC_BRANCH = 3'd1;
  typedef struct packed {
    logic [31:0] conba;
    logic [31:0] luout;
    logic [31:0] busb;
    logic [31:0] busa;
    logic [4:0]  shamt;
    logic [4:0]  rt;
    logic [4:0]  rs;
    logic [4:0]  addrc;
  } idex_data_t;
  typedef struct packed {
    logic       alusrc1;
    logic       alusrc2;
    logic       sign;
    logic       memwr;
    logic       memrd;
    logic       regwr;
    logic [2:0] pcsrc;
    logic [1:0] memtoreg;
    logic [5:0] alufun;
  } idex_ctrl_t;
  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] bus,
                                      input logic em_wr, input logic [4:0] em_rd, input logic [31:0] em_val,
                                      input logic wb_wr, input logic [4:0] wb_rd, input logic [31:0] wb_val);
    return (em_wr && em_rd != 5'd0 && em_rd == r) ? em_val :
           (wb_wr && wb_rd != 5'd0 && wb_rd == r) ? wb_val : bus;
  endfunction
endpackage

// File: rtl/pipeline_alu.sv
// pipeline_alu: combinational ALU (A, B, ALUFun, Sign -> Z); shifts take amount from A[4:0], value from B
module pipeline_alu
  import pipeline_ex_stage_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [5:0]  ALUFun,
  input  logic        Sign,
  output logic [31:0] Z
);
  logic lt;
  assign lt = Sign ? ($signed(A) < $signed(B)) : (A < B);
  always_comb begin
    Z = 32'd0;
    case (ALUFun)
      ALU_ADD:  Z = A + B;
      ALU_SUB:  Z = A - B;
      ALU_AND:  Z = A & B;
      ALU_OR:   Z = A | B;
      ALU_XOR:  Z = A ^ B;
      ALU_NOR:  Z = ~(A | B);
      ALU_PASS: Z = A;
      ALU_SLL:  Z = B << A[4:0];
      ALU_SRL:  Z = B >> A[4:0];
      ALU_SRA:  Z = $unsigned($signed(B) >>> A[4:0]);
      ALU_EQ:   Z = {31'd0, A == B};
      ALU_NE:   Z = {31'd0, A != B};
      ALU_LT:   Z = {31'd0, lt};
      ALU_LEZ:  Z = {31'd0, A[31] || A == 32'd0};
      ALU_LTZ:  Z = {31'd0, A[31]};
      ALU_GTZ:  Z = {31'd0, !A[31] && A != 32'd0};
      default:  Z = 32'd0;
    endcase
  end
endmodule

// File: rtl/pipeline_ex_stage.sv
// pipeline_ex_stage: execute stage -- unpacks ID/EX, forwards from EX/MEM and MEM/WB, runs the ALU, resolves branches, registers EX/MEM
module pipeline_ex_stage
  import pipeline_ex_stage_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         Bubble,
  input  logic [148:0] IDEX_data,
  input  logic [17:0]  IDEX_control,
  input  logic         MEMWB_RegWr,
  input  logic [4:0]   MEMWB_AddrC,
  input  logic [31:0]  MEMWB_WrData,
  output logic         BranchTaken,
  output logic [31:0]  BranchTarget,
  output logic [31:0]  EXMEM_ALUOut,
  output logic [31:0]  EXMEM_StoreData,
  output logic [4:0]   EXMEM_AddrC,
  output logic         EXMEM_RegWr,
  output logic         EXMEM_MemRd,
  output logic         EXMEM_MemWr,
  output logic [1:0]   EXMEM_MemToReg
);
  idex_data_t d;
  idex_ctrl_t c;
  logic [31:0] fwd_a, fwd_b, alu_a, alu_b, alu_z;
  logic unused_top_bits;
  assign d = IDEX_data[147:0];
  assign c = IDEX_control[16:0];
  assign unused_top_bits = IDEX_data[148] ^ IDEX_control[17];
  assign fwd_a = fwd(d.rs, d.busa, EXMEM_RegWr, EXMEM_AddrC, EXMEM_ALUOut, MEMWB_RegWr, MEMWB_AddrC, MEMWB_WrData);
  assign fwd_b = fwd(d.rt, d.busb, EXMEM_RegWr, EXMEM_AddrC, EXMEM_ALUOut, MEMWB_RegWr, MEMWB_AddrC, MEMWB_WrData);
  assign alu_a = c.alusrc1 ? {27'd0, d.shamt} : fwd_a;
  assign alu_b = c.alusrc2 ? d.luout : fwd_b;
  assign BranchTaken = (c.pcsrc == PCSRC_BRANCH) && alu_z[0];
  assign BranchTarget = d.conba;
  pipeline_alu u_alu (
    .A(alu_a),
    .B(alu_b),
    .ALUFun(c.alufun),
    .Sign(c.sign),
    .Z(alu_z)
  );
  // A taken branch still loads EX/MEM; squashing the wrong-path work is upstream's job.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || Bubble) begin
      EXMEM_ALUOut    <= 32'd0;
      EXMEM_StoreData <= 32'd0;
      EXMEM_AddrC     <= 5'd0;
      EXMEM_RegWr     <= 1'b0;
      EXMEM_MemRd     <= 1'b0;
      EXMEM_MemWr     <= 1'b0;
      EXMEM_MemToReg  <= 2'd0;
    end else begin
      EXMEM_ALUOut    <= alu_z;
      EXMEM_StoreData <= fwd_b;
      EXMEM_AddrC     <= d.addrc;
      EXMEM_RegWr     <= c.regwr;
      EXMEM_MemRd     <= c.memrd;
      EXMEM_MemWr     <= c.memwr;
      EXMEM_MemToReg  <= c.memtoreg;
    end
  end
endmodule
